// File: rtl/pattern_feeder.sv
// Purpose : programmable-rate pattern source writing DATA_BYTES-wide words into a circular TX buffer.
// Latency : a divider tick raises pending; the word is written on the next edge when the buffer has room.
// Backpress: buffer full holds the pending word and the generator (no loss), raises stalled and counts stall cycles.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   enable                 run request (IDLE->RUN, RUN/DONE->IDLE when dropped)
//   mode, burst_len        pattern select and words per burst (0 = continuous), sampled on IDLE->RUN
//   const_word             word for constant mode, read live
//   tx_buf, tx_buf_send    flat buffer image and producer pointer
//   tx_buf_sent            consumer pointer from the bridge
//   stalled, stall_count   pending word blocked by a full buffer; saturating stall-cycle count
//   words_sent, burst_done words written since start; one-cycle pulse on finite-burst completion
//   busy                   high in RUN
module pattern_feeder #(
    parameter int TX_BUFFER       = 16,
    parameter int TX_BUFFER_WIDTH = $clog2(TX_BUFFER),
    parameter int DATA_BYTES      = 1,
    parameter int CLOCK_RATE      = 100000000,
    parameter int FREQ            = 1000000,
    parameter int BURST_WIDTH     = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic [1:0]                      mode,
    input  logic [8*DATA_BYTES-1:0]         const_word,
    input  logic [BURST_WIDTH-1:0]          burst_len,
    output logic [TX_BUFFER*8*DATA_BYTES-1:0] tx_buf,
    output logic [TX_BUFFER_WIDTH-1:0]      tx_buf_send,
    input  logic [TX_BUFFER_WIDTH-1:0]      tx_buf_sent,
    output logic                            stalled,
    output logic [15:0]                     stall_count,
    output logic [BURST_WIDTH-1:0]          words_sent,
    output logic                            burst_done,
    output logic                            busy
);

    localparam int W     = 8 * DATA_BYTES;
    localparam int RATE  = CLOCK_RATE / FREQ;
    localparam int DIV_W = (RATE > 1) ? $clog2(RATE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state, state_nxt;
    logic [DIV_W-1:0]           div;
    logic                       pending;
    logic [1:0]                 mode_q;
    logic [BURST_WIDTH-1:0]     burst_len_q;
    logic [W-1:0]               cnt;
    logic [30:0]                lfsr;
    logic [W-1:0]               walk;
    logic [W-1:0]               cur_word;
    logic [W-1:0]               mem [TX_BUFFER];

    logic                       start;
    logic                       active;
    logic                       full;
    logic                       tick;
    logic                       write;
    logic                       last_word;
    logic [TX_BUFFER_WIDTH-1:0] send_inc;
    logic [BURST_WIDTH-1:0]     words_inc;

    assign send_inc  = tx_buf_send + 1'b1;
    assign words_inc = words_sent + 1'b1;
    assign start     = (state == IDLE) && enable;
    assign active    = (state == RUN) && enable;
    // One slot is always left empty so send == sent unambiguously means empty.
    assign full      = (send_inc == tx_buf_sent);
    assign tick      = active && (div == DIV_W'(RATE - 1));
    assign write     = active && pending && !full;
    assign last_word = (burst_len_q != '0) && (words_inc == burst_len_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable)                state_nxt = IDLE;
                     else if (write && last_word) state_nxt = DONE;
            DONE:    if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy    = (state == RUN);
        stalled = active && pending && full;
    end

    always_comb begin
        cur_word = cnt;
        case (mode_q)
            2'd0:    cur_word = cnt;
            2'd1:    cur_word = lfsr[W-1:0];
            2'd2:    cur_word = const_word;
            default: cur_word = walk;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div         <= '0;
            pending     <= 1'b0;
            mode_q      <= 2'd0;
            burst_len_q <= '0;
            cnt         <= '0;
            lfsr        <= 31'h1;
            walk        <= W'(1);
            tx_buf_send <= '0;
            words_sent  <= '0;
            stall_count <= '0;
            burst_done  <= 1'b0;
        end else begin
            burst_done <= write && last_word;
            if (stalled && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 1'b1;

            if (start) begin
                mode_q      <= mode;
                burst_len_q <= burst_len;
                cnt         <= '0;
                lfsr        <= 31'h1;
                walk        <= W'(1);
                words_sent  <= '0;
                div         <= '0;
                pending     <= 1'b0;
            end else if (active) begin
                div <= tick ? '0 : div + 1'b1;
                // A tick may re-arm pending in the cycle its predecessor is written
                // (one word per cycle at RATE=1); otherwise a tick on a held word is lost.
                pending <= write ? tick : (pending | tick);
                if (write) begin
                    tx_buf_send <= send_inc;
                    words_sent  <= words_inc;
                    // All generators step together; only the latched mode is observed.
                    cnt  <= cnt + 1'b1;
                    lfsr <= {lfsr[29:0], lfsr[30] ^ lfsr[27]};
                    walk <= {walk[W-2:0], walk[W-1]};
                end
            end else begin
                pending <= 1'b0;
            end
        end
    end

    // Buffer contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (write) mem[tx_buf_send] <= cur_word;
    end

    for (genvar i = 0; i < TX_BUFFER; i++) begin : g_flat
        assign tx_buf[i*W +: W] = mem[i];
    end

endmodule

// File: tb/tb_pattern_feeder.sv
module tb_pattern_feeder;

    localparam int TXB = 16;
    localparam int TXW = 4;
    localparam int W   = 16;
    localparam int BW  = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [W-1:0]     const_word = 16'hA5A5;
    logic [BW-1:0]    burst_len = '0;
    logic [TXB*W-1:0] tx_buf;
    logic [TXW-1:0]   tx_buf_send;
    logic [TXW-1:0]   tx_buf_sent = '0;
    logic             stalled;
    logic [15:0]      stall_count;
    logic [BW-1:0]    words_sent;
    logic             burst_done;
    logic             busy;

    pattern_feeder #(
        .TX_BUFFER(TXB), .TX_BUFFER_WIDTH(TXW), .DATA_BYTES(2),
        .CLOCK_RATE(100000000), .FREQ(25000000), .BURST_WIDTH(BW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .const_word(const_word), .burst_len(burst_len), .tx_buf(tx_buf),
        .tx_buf_send(tx_buf_send), .tx_buf_sent(tx_buf_sent), .stalled(stalled),
        .stall_count(stall_count), .words_sent(words_sent),
        .burst_done(burst_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Consumer model and capture of every word the DUT commits.
    logic [W-1:0]   cap_q[$];
    int             cap_cyc[$];
    int             cyc = 0;
    logic [TXW-1:0] last_send = '0;
    bit             track = 1'b0;
    logic [TXW-1:0] sent_hold = '0;
    int             seen_stall = 0;
    int             pulses = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && tx_buf_send != last_send) begin
            cap_q.push_back(tx_buf[last_send*W +: W]);
            cap_cyc.push_back(cyc);
        end
        last_send = tx_buf_send;
        if (stalled)    seen_stall++;
        if (burst_done) pulses++;
        tx_buf_sent = track ? tx_buf_send : sent_hold;
    end

    task automatic do_reset();
        @(negedge clk);
        enable = 1'b0;
        track  = 1'b0;
        sent_hold = '0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_words(input int n, input int budget, input string tag);
        int k = 0;
        while (cap_q.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(tag, 32'(cap_q.size() >= n), 1);
    endtask

    task automatic wait_stall(input int budget, input string tag);
        int k = 0;
        while (!stalled && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(tag, 32'(stalled), 1);
    endtask

    int           base;
    int           s0;
    int           p0;
    logic [15:0]  sc;
    logic [TXW-1:0] sv;
    logic [W-1:0] slot;
    logic [30:0]  model;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_send", 32'(tx_buf_send), 0);
        check("rst_stalled", 32'(stalled), 0);
        check("rst_scnt", 32'(stall_count), 0);
        check("rst_wsent", 32'(words_sent), 0);
        check("rst_bdone", 32'(burst_done), 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Counter mode, consumer keeps up: 16 words, pointer wraps, no stalls
        base = cap_q.size();
        s0 = seen_stall;
        mode = 2'd0; burst_len = '0; track = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        wait_words(base + 16, 200, "t1_tmo");
        for (int i = 0; i < 16; i++)
            if (cap_q.size() > base + i) check("t1_word", 32'(cap_q[base+i]), 32'(i));
        check("t1_gap1", 32'(cap_cyc[base+1] - cap_cyc[base]), 4);
        check("t1_gap2", 32'(cap_cyc[base+2] - cap_cyc[base+1]), 4);
        check("t1_wrap", 32'(tx_buf_send), 0);
        check("t1_nostall", 32'(seen_stall - s0), 0);
        check("t1_busy", 32'(busy), 1);

        // Consumer held at 0: fills 15 slots then stalls, no value skipped on release
        do_reset();
        base = cap_q.size();
        mode = 2'd0; sent_hold = '0;
        enable = 1'b1;
        wait_words(base + 15, 200, "t2_tmo");
        wait_stall(20, "t2_stalled");
        check("t2_send", 32'(tx_buf_send), 15);
        check("t2_wsent", 32'(words_sent), 15);
        check("t2_last", 32'(cap_q[base+14]), 32'h000E);
        sc = stall_count;
        @(negedge clk);
        #1;
        check("t2_scnt_inc", 32'(stall_count), 32'(sc + 16'd1));
        sent_hold = 4'd5;
        wait_words(base + 16, 20, "t2_rel_tmo");
        if (cap_q.size() > base + 15) check("t2_next", 32'(cap_q[base+15]), 32'h000F);
        slot = tx_buf[15*W +: W];
        check("t2_slot15", 32'(slot), 32'h000F);
        check("t2_send_wrap", 32'(tx_buf_send), 0);
        check("t2_unstall", 32'(stalled), 0);

        // Drop enable while pending and full
        wait_stall(60, "t5_stalled");
        sv = tx_buf_send;
        check("t5_send_full", 32'(sv), 4);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        #1;
        check("t5_busy", 32'(busy), 0);
        check("t5_stalled0", 32'(stalled), 0);
        check("t5_send_kept", 32'(tx_buf_send), 32'(sv));
        track = 1'b1;
        @(negedge clk);
        base = cap_q.size();
        enable = 1'b1;
        @(negedge clk);
        #1;
        check("t5_wsent0", 32'(words_sent), 0);
        wait_words(base + 1, 40, "t5_tmo");
        if (cap_q.size() > base) check("t5_restart", 32'(cap_q[base]), 0);

        // Finite burst, walking-one
        do_reset();
        base = cap_q.size();
        p0 = pulses;
        mode = 2'd3; burst_len = 16'd3; track = 1'b1;
        enable = 1'b1;
        wait_words(base + 3, 100, "t3_tmo");
        if (cap_q.size() >= base + 3) begin
            check("t3_w0", 32'(cap_q[base]), 32'h0001);
            check("t3_w1", 32'(cap_q[base+1]), 32'h0002);
            check("t3_w2", 32'(cap_q[base+2]), 32'h0004);
        end
        repeat (30) @(negedge clk);
        #1;
        check("t3_pulses", 32'(pulses - p0), 1);
        check("t3_busy", 32'(busy), 0);
        check("t3_nowrite", 32'(cap_q.size() - base), 3);
        check("t3_send", 32'(tx_buf_send), 3);
        check("t3_wsent", 32'(words_sent), 3);

        // PRBS31 against a reference model
        do_reset();
        base = cap_q.size();
        mode = 2'd1; burst_len = '0; track = 1'b1;
        enable = 1'b1;
        wait_words(base + 1000, 4500, "t4_tmo");
        if (cap_q.size() >= base + 3) begin
            check("t4_h0", 32'(cap_q[base]), 32'h0001);
            check("t4_h1", 32'(cap_q[base+1]), 32'h0002);
            check("t4_h2", 32'(cap_q[base+2]), 32'h0004);
        end
        model = 31'h1;
        for (int i = 0; i < 1000; i++) begin
            if (cap_q.size() > base + i) check("t4_prbs", 32'(cap_q[base+i]), 32'(model[15:0]));
            model = {model[29:0], model[30] ^ model[27]};
        end

        // Constant mode, const_word read live
        do_reset();
        base = cap_q.size();
        mode = 2'd2; const_word = 16'hA5A5; track = 1'b1;
        enable = 1'b1;
        wait_words(base + 2, 40, "tc_tmo");
        if (cap_q.size() >= base + 2) begin
            check("tc_w0", 32'(cap_q[base]), 32'hA5A5);
            check("tc_w1", 32'(cap_q[base+1]), 32'hA5A5);
        end
        const_word = 16'h5A5A;
        base = cap_q.size();
        wait_words(base + 1, 20, "tc_tmo2");
        if (cap_q.size() > base) check("tc_live", 32'(cap_q[base]), 32'h5A5A);

        // Long stall saturates stall_count; async reset mid-cycle clears everything
        do_reset();
        mode = 2'd0; sent_hold = '0; track = 1'b0;
        enable = 1'b1;
        repeat (65700) @(negedge clk);
        #1;
        check("t6_sat", 32'(stall_count), 32'hFFFF);
        check("t6_stalled", 32'(stalled), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_send", 32'(tx_buf_send), 0);
        check("t6_scnt", 32'(stall_count), 0);
        check("t6_stalled0", 32'(stalled), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_wsent", 32'(words_sent), 0);
        check("t6_bdone", 32'(burst_done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
